clk_synchronizer: RTL and testbench
===================================

# clk_synchronizer

Multi-bit clock-domain-crossing synchronizer. It brings a WIDTH-bit bus (D) into the clockOut domain and presents a glitch-filtered, bus-coherent copy on Q. D is treated as fully asynchronous to clockOut: its source domain is not a port of this block. The block sits at the boundary between the JTAG TCK-side logic and the system-clock logic of the JTAG interface.

## Interface
Parameters:
- WIDTH, default 10: bus width in bits, ≥1.
- STAGES, default 2: synchronizer flops per bit, ≥2.
- STABLE_CYCLES, default 1, range 0..15: number of extra consecutive clockOut edges the synchronized bus must hold before Q updates.

Ports:
- clockOut, input, 1: the single clock, rising-edge. One clock; reset is asynchronous and active-low.
- n_reset, input, 1: asynchronous, active-low reset.
- D, input, WIDTH: asynchronous bus to synchronize.
- Q, output, WIDTH: synchronized, filtered bus, registered.
- changed, output, 1: one-cycle pulse when Q takes a new, different value.

## Operation
- Each bit of D passes through its own chain of STAGES flops clocked by clockOut. The last stage is the bus s.
- A history of s over the previous STABLE_CYCLES edges is kept in registers h[1..STABLE_CYCLES].
- On each edge, Q ← s only if s equals every h[i]. Otherwise Q holds. History always shifts in s.
- STABLE_CYCLES=0: Q ← s on every edge, with no filtering.
- changed is registered. It is 1 for exactly the cycle after an edge where Q loaded a value differing from its old Q; otherwise 0.
- Bus coherency:
  - A D transition whose bits resolve on different edges makes s hold mixed values transiently.
  - The stability filter suppresses such a mix unless it persists STABLE_CYCLES+1 edges.
- A D value held for fewer than STABLE_CYCLES+1 clockOut periods may be dropped; this is required behaviour, not an error.
- Reset, while n_reset=0, regardless of clock:
  - All chain flops, history, Q and changed are set to 0.
  - Reset mid-transfer discards the in-flight value.
- After n_reset deasserts, the first capture happens on the first clockOut rising edge with n_reset=1.

## Timing
- Define E0 as the clockOut edge at which D (stable, setup met) is captured by stage 1.
- s shows the new value after edge E0+STAGES−1.
- Q shows the new value after edge E0+STAGES+STABLE_CYCLES−1+1, i.e. E0+3 with defaults. changed is high during that same following cycle.
- Latency with defaults: 3 clockOut edges after the capture edge, so 4 edges counting E0.
- If D changes again before Q loads, the filter restarts. No intermediate value is guaranteed to appear.
- If D equals the current Q, Q does not change and changed stays 0.
- The first-stage flops carry the synthesis/timing attribute marking them as asynchronous inputs (false path into stage 1).

## Structure
- No shared package is required. The parameter legality checks (STAGES≥2, STABLE_CYCLES≤15) are elaboration-time assertions inside the module.
- One natural sub-module is sync_chain: a 1-bit, STAGES-deep flop chain with asynchronous active-low reset, instantiated WIDTH times via generate.
- The filter, history and change detection live in the top module.

## Test plan
- Reset: n_reset=0 with D=0x3FF and clockOut toggling → Q=0x000 and changed=0 throughout. Release reset → Q=0x3FF after 4 edges.
- Steady update: D 0x000→0x3FF, held 10 clockOut cycles → Q=0x3FF after edge E0+3, changed high for exactly one cycle, Q then stable.
- Glitch rejection (defaults): D=0x3FF for exactly 1 clockOut period, then back to 0x000 → Q stays 0x000 and changed never asserts.
- Back-to-back changes: D=0x3FF, then 0x000, then 0x1FF, each held 10 ns with clockOut period 6 ns, final value held → Q ends at 0x1FF. Every value Q takes is one of 0x000, 0x3FF, 0x1FF; no mixed-bit values.
- STABLE_CYCLES=0, STAGES=3: D 0x000→0x155 → Q=0x155 after edge E0+3.
- Asynchronous reset mid-transfer: assert n_reset one edge after E0, between clock edges → Q immediately 0x000. After release, Q re-acquires the held D with full latency.

Source files
------------

// File: rtl/clk_synchronizer_pkg.sv
// Shared constants for the clk_synchronizer CDC block: defaults and legal
// parameter bounds used by the elaboration checks.
package clk_synchronizer_pkg;

  localparam int DEF_WIDTH         = 10;
  localparam int DEF_STAGES        = 2;
  localparam int DEF_STABLE_CYCLES = 1;
  localparam int MIN_STAGES        = 2;
  localparam int MAX_STABLE_CYCLES = 15;

endpackage

// File: rtl/clk_synchronizer_sync_chain.sv
// One-bit multi-flop synchronizer chain with async active-low reset.
// ff[0] is the metastability-catching flop fed directly by the async input.
module clk_synchronizer_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clockOut,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  // The whole chain is tagged so tools keep the flops adjacent and treat the
  // path into ff[0] as a false path.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] ff;

  always_ff @(posedge clockOut or negedge n_reset) begin
    if (!n_reset) ff <= '0;
    else          ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_synchronizer.sv
// Multi-bit CDC synchronizer: per-bit flop chains followed by a stability
// filter so Q only ever loads a bus value that held for STABLE_CYCLES+1 edges.
module clk_synchronizer
  import clk_synchronizer_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STAGES        = DEF_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clockOut,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             changed
);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("clk_synchronizer: STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 0 || STABLE_CYCLES > MAX_STABLE_CYCLES) begin : g_bad_stable
    $error("clk_synchronizer: STABLE_CYCLES must be in 0..15");
  end

  logic [WIDTH-1:0] s;
  logic             stable;

  for (genvar b = 0; b < WIDTH; b++) begin : g_lane
    clk_synchronizer_sync_chain #(.STAGES(STAGES)) u_chain (
      .clockOut (clockOut),
      .n_reset  (n_reset),
      .d        (D[b]),
      .q        (s[b])
    );
  end

  if (STABLE_CYCLES == 0) begin : g_nofilt
    assign stable = 1'b1;
  end else begin : g_filt
    // hist[0] is s from the previous edge, hist[k] is k+1 edges old.
    logic [STABLE_CYCLES-1:0][WIDTH-1:0] hist;

    always_ff @(posedge clockOut or negedge n_reset) begin
      if (!n_reset) begin
        hist <= '0;
      end else begin
        hist[0] <= s;
        for (int i = 1; i < STABLE_CYCLES; i++) hist[i] <= hist[i-1];
      end
    end

    // A transiently mixed bus never matches its whole history, so it is held off.
    always_comb begin
      stable = 1'b1;
      for (int i = 0; i < STABLE_CYCLES; i++)
        if (hist[i] != s) stable = 1'b0;
    end
  end

  always_ff @(posedge clockOut or negedge n_reset) begin
    if (!n_reset) begin
      Q       <= '0;
      changed <= 1'b0;
    end else begin
      changed <= stable && (s != Q);
      if (stable) Q <= s;
    end
  end

endmodule

// File: tb/tb_clk_synchronizer.sv
// Directed bench for clk_synchronizer: default instance plus a STAGES=3,
// STABLE_CYCLES=0 instance, both on one 6 ns clockOut.
module tb_clk_synchronizer;

  logic       clockOut = 1'b0;
  logic       n_reset  = 1'b0;
  logic [9:0] d_a = '0, d_b = '0;
  logic [9:0] q_a, q_b;
  logic       chg_a, chg_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #3 clockOut = ~clockOut;

  clk_synchronizer u_dut_a (
    .clockOut (clockOut), .n_reset (n_reset), .D (d_a), .Q (q_a), .changed (chg_a)
  );

  clk_synchronizer #(.WIDTH(10), .STAGES(3), .STABLE_CYCLES(0)) u_dut_b (
    .clockOut (clockOut), .n_reset (n_reset), .D (d_b), .Q (q_b), .changed (chg_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Wait n rising edges, then land on the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clockOut);
    @(negedge clockOut);
  endtask

  function automatic logic legal(input logic [9:0] v);
    return (v == 10'h000) || (v == 10'h3FF) || (v == 10'h1FF);
  endfunction

  initial begin
    // Reset held with D=3FF and clock running
    d_a = 10'h3FF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clockOut);
      chk("rst_q",   q_a,   10'h000);
      chk("rst_chg", chg_a, 1'b0);
    end
    chk("rst_q_b", q_b, 10'h000);

    // Release at a falling edge: next rising edge is the first capture (E0)
    n_reset = 1'b1;
    edges(3);
    chk("rel_q_e2",   q_a,   10'h000);
    edges(1);
    chk("rel_q_e3",   q_a,   10'h3FF);
    chk("rel_chg_e3", chg_a, 1'b1);
    edges(1);
    chk("rel_chg_off", chg_a, 1'b0);

    // Steady update 000 -> 3FF
    d_a = 10'h000;
    edges(8);
    chk("upd_base", q_a, 10'h000);
    d_a = 10'h3FF;
    edges(3);
    chk("upd_q_e2",  q_a,   10'h000);
    chk("upd_chg_e2", chg_a, 1'b0);
    edges(1);
    chk("upd_q_e3",  q_a,   10'h3FF);
    chk("upd_chg_e3", chg_a, 1'b1);
    edges(1);
    chk("upd_chg_off", chg_a, 1'b0);
    edges(5);
    chk("upd_hold",   q_a,   10'h3FF);
    chk("upd_hold_c", chg_a, 1'b0);

    // Same value as Q: no change pulse
    d_a = 10'h3FF;
    edges(5);
    chk("same_chg", chg_a, 1'b0);

    // Glitch: 3FF present for exactly one clock period
    d_a = 10'h000;
    edges(8);
    chk("gl_base", q_a, 10'h000);
    d_a = 10'h3FF;
    @(posedge clockOut);
    @(negedge clockOut);
    d_a = 10'h000;
    for (int i = 0; i < 8; i++) begin
      chk("gl_q",   q_a,   10'h000);
      chk("gl_chg", chg_a, 1'b0);
      @(negedge clockOut);
    end

    // Back-to-back values changing off the clock grid
    fork
      begin
        d_a = 10'h3FF;
        #10 d_a = 10'h000;
        #10 d_a = 10'h1FF;
      end
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge clockOut);
          chk("b2b_legal", {31'd0, legal(q_a)}, 32'd1);
        end
      end
    join
    chk("b2b_final", q_a, 10'h1FF);

    // Unfiltered STAGES=3 instance: 000 -> 155
    d_b = 10'h155;
    edges(3);
    chk("sc0_q_e2", q_b, 10'h000);
    edges(1);
    chk("sc0_q_e3",   q_b,   10'h155);
    chk("sc0_chg_e3", chg_b, 1'b1);
    edges(1);
    chk("sc0_chg_off", chg_b, 1'b0);

    // Async reset one edge after capture, between edges
    d_a = 10'h3FF;
    @(posedge clockOut);
    @(posedge clockOut);
    #1 n_reset = 1'b0;
    #1;
    chk("ar_q",   q_a,   10'h000);
    chk("ar_chg", chg_a, 1'b0);
    chk("ar_q_b", q_b,   10'h000);
    edges(2);
    chk("ar_hold", q_a, 10'h000);
    n_reset = 1'b1;
    edges(3);
    chk("ar_q_e2", q_a, 10'h000);
    edges(1);
    chk("ar_q_e3",   q_a,   10'h3FF);
    chk("ar_chg_e3", chg_a, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
